// File: rtl/bit_interleaver.sv
// QPSK block interleaver: writes each NCBPS-bit block permuted into one of two
// ping-pong banks and drains the other sequentially. Optional macro: INTLV_BYPASS_EN.
module bit_interleaver #(
  parameter int unsigned NCBPS = 192,
  parameter int unsigned D     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  input  logic valid_in,
  output logic ready_out,
  output logic serial_out,
  output logic valid_out,
  input  logic ready_in
`ifdef INTLV_BYPASS_EN
  ,
  input  logic bypass
`endif
);

  localparam int unsigned ROWS = NCBPS / D;
  localparam int unsigned AW   = (NCBPS > 1) ? $clog2(NCBPS) : 1;
  localparam int unsigned CW   = (D > 1) ? $clog2(D) : 1;

  logic [NCBPS-1:0] mem_q [2];

  logic          init_q;
  logic          wr_bank_q, rd_bank_q;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] k_q, row_q, addr_q, rd_addr_q;
  logic [CW-1:0] col_q;
  logic          serial_out_q, valid_out_q;

  logic          wr_fire, rd_fire, blk_last, rd_last, byp_cur;
  logic [AW-1:0] wr_addr;

  assign ready_out  = init_q && !full_q[wr_bank_q];
  assign serial_out = serial_out_q;
  assign valid_out  = valid_out_q;

  assign wr_fire  = valid_in && ready_out;
  assign rd_fire  = full_q[rd_bank_q] && (!valid_out_q || ready_in);
  assign blk_last = (k_q == AW'(NCBPS - 1));
  assign rd_last  = (rd_addr_q == AW'(NCBPS - 1));

`ifdef INTLV_BYPASS_EN
  // Bypass is latched with the first bit of a block and governs the whole block.
  logic byp_q;
  assign byp_cur = (k_q == '0) ? bypass : byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         byp_q <= 1'b0;
    else if (wr_fire && (k_q == '0))    byp_q <= bypass;
  end
`else
  assign byp_cur = 1'b0;
`endif

  assign wr_addr = byp_cur ? k_q : addr_q;

  // Fill and drain flags are independent; both may change on the same edge.
  always_comb begin
    full_d = full_q;
    if (wr_fire && blk_last) full_d[wr_bank_q] = 1'b1;
    if (rd_fire && rd_last)  full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_addr] <= serial_in;
  end

  // Writer: k/col/row counters generate m_k incrementally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      k_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
    end else begin
      init_q <= 1'b1;
      full_q <= full_d;
      if (wr_fire) begin
        if (blk_last) begin
          wr_bank_q <= ~wr_bank_q;
          k_q       <= '0;
          col_q     <= '0;
          row_q     <= '0;
          addr_q    <= '0;
        end else begin
          k_q <= k_q + AW'(1);
          if (col_q == CW'(D - 1)) begin
            col_q  <= '0;
            row_q  <= row_q + AW'(1);
            addr_q <= row_q + AW'(1);
          end else begin
            col_q  <= col_q + CW'(1);
            addr_q <= addr_q + AW'(ROWS);
          end
        end
      end
    end
  end

  // Reader: sequential drain into a holding output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      serial_out_q <= 1'b0;
      valid_out_q  <= 1'b0;
    end else if (rd_fire) begin
      serial_out_q <= mem_q[rd_bank_q][rd_addr_q];
      valid_out_q  <= 1'b1;
      if (rd_last) begin
        rd_addr_q <= '0;
        rd_bank_q <= ~rd_bank_q;
      end else begin
        rd_addr_q <= rd_addr_q + AW'(1);
      end
    end else if (ready_in) begin
      valid_out_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_interleaver.sv
// Randomized bench for bit_interleaver with a queue-based m_k permutation model.
module tb_bit_interleaver;

  localparam int NCBPS = 192;
  localparam int D     = 16;
  localparam int ROWS  = NCBPS / D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic serial_in = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out, serial_out, valid_out;
  logic ready_in = 1'b0;
`ifdef INTLV_BYPASS_EN
  logic bypass = 1'b0;
`endif

  bit_interleaver #(.NCBPS(NCBPS), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .valid_in(valid_in),
    .ready_out(ready_out), .serial_out(serial_out), .valid_out(valid_out),
    .ready_in(ready_in)
`ifdef INTLV_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic in_q[$];
  logic exp_q[$];
  logic got_q[$];
  logic blk_byp = 1'b0;
  bit   prev_stall = 0;
  logic prev_bit = 1'b0;
  int   rmode = 0;   // 0: ready_in=1, 1: random, 2: ready_in=0

  // Phase-2 continuity monitors
  bit cont_en = 0, cont_first = 0;
  int cont_ins = 0, cont_outs = 0, ro_drops = 0, vo_bubbles = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Output index of input bit k, straight from the permutation formula.
  function automatic int perm(input int k, input logic byp);
    return byp ? k : ROWS * (k % D) + k / D;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ready_in = 1'b1;
      1:       ready_in = ($urandom_range(0, 2) != 0);
      default: ready_in = 1'b0;
    endcase
  end

  // Model and compare: values at negedge are those the next rising edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_q.delete(); exp_q.delete(); got_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!valid_out || serial_out !== prev_bit) begin
          errors++;
          $display("FAIL hold: valid_out=%b serial_out=%b expected 1/%b", valid_out, serial_out, prev_bit);
        end
      end
      if (valid_in && ready_out) begin
`ifdef INTLV_BYPASS_EN
        if (in_q.size() == 0) blk_byp = bypass;
`endif
        in_q.push_back(serial_in);
        if (cont_en) cont_ins++;
        if (in_q.size() == NCBPS) begin
          logic blk[NCBPS];
          for (int k = 0; k < NCBPS; k++) blk[perm(k, blk_byp)] = in_q[k];
          for (int m = 0; m < NCBPS; m++) exp_q.push_back(blk[m]);
          in_q.delete();
        end
      end
      if (cont_en) begin
        if (cont_ins < 3*NCBPS && !ready_out) ro_drops++;
        if (cont_first && cont_outs < 3*NCBPS && !valid_out) vo_bubbles++;
      end
      if (valid_out && ready_in) begin
        if (cont_en) begin cont_first = 1; cont_outs++; end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output: got bit %b expected none", serial_out);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (serial_out !== e) begin
            errors++;
            $display("FAIL data: got %b expected %b at %0t", serial_out, e, $time);
          end
          got_q.push_back(serial_out);
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_bit   = serial_out;
    end
  end

  task automatic push_bit(input logic b, input bit gaps);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_in  = 1'b0;
        serial_in = 1'($urandom);
      end else begin
        valid_in  = 1'b1;
        serial_in = b;
      end
      @(negedge clk);
      done = valid_in && ready_out;
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL push_timeout: ready_out stuck at %b expected 1", ready_out);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "input stalled");
      end
    end
  endtask

  task automatic send_block(input logic [NCBPS-1:0] bits, input bit gaps, input logic byp);
`ifdef INTLV_BYPASS_EN
    bypass = byp;
`else
    if (byp) $display("note: bypass requested without INTLV_BYPASS_EN");
`endif
    for (int k = 0; k < NCBPS; k++) push_bit(bits[k], gaps);
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle_in();
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk); n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  function automatic int find_one(input int blk);
    for (int i = 0; i < NCBPS; i++)
      if (got_q[blk*NCBPS + i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [NCBPS-1:0] rand_blk();
    logic [NCBPS-1:0] v;
    for (int i = 0; i < NCBPS; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  initial begin
    logic [NCBPS-1:0] v;
    int ks[4];
    int want[4];
    int n;
    ks   = '{1, 16, 191, 0};
    want = '{12, 1, 191, 0};

    #12;
    chk("reset_ready_out", int'(ready_out), 0);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_serial_out", int'(serial_out), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("init_ready_out", int'(ready_out), 1);

    // 1: single-one blocks
    rmode = 0;
    for (int b = 0; b < 4; b++) begin
      v = '0; v[ks[b]] = 1'b1;
      send_block(v, 0, 1'b0);
    end
    drain("t1_drain");
    chk("t1_got_count", got_q.size(), 4*NCBPS);
    for (int b = 0; b < 4; b++) chk($sformatf("t1_index_k%0d", ks[b]), find_one(b), want[b]);
    got_q.delete();

    // 2: continuous streaming
    cont_en = 1;
    for (int b = 0; b < 3; b++) send_block(rand_blk(), 0, 1'b0);
    drain("t2_drain");
    cont_en = 0;
    chk("t2_ready_drops", ro_drops, 0);
    chk("t2_valid_bubbles", vo_bubbles, 0);
    chk("t2_outputs", cont_outs, 3*NCBPS);

    // 3: downstream stall with both banks full
    rmode = 2;
    repeat (2) @(posedge clk); #1;
    for (int b = 0; b < 2; b++) send_block(rand_blk(), 0, 1'b0);
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3_ready_low", int'(ready_out), 0);
    chk("t3_valid_held", int'(valid_out), 1);
    chk("t3_bit0_held", int'(serial_out), int'(exp_q[0]));
    rmode = 0;
    n = 0;
    while (!ready_out && n < 300) begin @(negedge clk); n++; end
    chk("t3_ready_return", int'(ready_out), 1);
    chk("t3_free_latency_ok", int'(n >= NCBPS - 2 && n <= NCBPS + 3), 1);
    drain("t3_drain");

    // 4: random gaps on both sides, 10 blocks
    rmode = 1;
    for (int b = 0; b < 10; b++) send_block(rand_blk(), 1, 1'b0);
    drain("t4_drain");
    rmode = 0;

    // 5: reset mid-block while output is stalled
    rmode = 2;
    repeat (2) @(posedge clk); #1;
    send_block(rand_blk(), 0, 1'b0);
    v = rand_blk();
    for (int k = 0; k < 100; k++) push_bit(v[k], 0);
    idle_in();
    @(posedge clk); #1;
    chk("t5_pre_valid", int'(valid_out), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready_out", int'(ready_out), 0);
    chk("t5_rst_valid_out", int'(valid_out), 0);
    chk("t5_rst_serial_out", int'(serial_out), 0);
    rmode = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    v = '0; v[16] = 1'b1;
    send_block(v, 0, 1'b0);
    drain("t5_drain");
    chk("t5_index_k16", find_one(0), 1);
    got_q.delete();

`ifdef INTLV_BYPASS_EN
    // 6: bypass on the middle block only
    for (int b = 0; b < 3; b++) begin
      v = '0; v[1] = 1'b1;
      send_block(v, 0, (b == 1));
    end
    drain("t6_drain");
    chk("t6_blk1_interleaved", find_one(0), 12);
    chk("t6_blk2_bypass", find_one(1), 1);
    chk("t6_blk3_interleaved", find_one(2), 12);
`endif

    chk("end_valid_out", int'(valid_out), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
